// File: rtl/ctl_pkg.sv
// Shared types and helpers for the CTI-8 writable control store.
package ctl_pkg;

  localparam int CW_W           = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int LOOKUP_W       = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } ctl_state_t;

  // Full lookup key; the store uses its low ADDR_W bits.
  function automatic logic [LOOKUP_W-1:0] addr_of(
    input logic [7:0] flags,
    input logic [7:0] instruction,
    input logic [3:0] state
  );
    return {flags, instruction, state};
  endfunction

endpackage

// File: rtl/control_store_loader_if.sv
// Image-load handshake and control-word lookup bundle for control_store_loader.
interface control_store_loader_if;
  import ctl_pkg::*;

  logic            clk_en;
  logic            load_start;
  logic [7:0]      load_data;
  logic            load_valid;
  logic            load_ready;
  logic            load_done;
  logic            loaded;
  logic [7:0]      instruction;
  logic [3:0]      state;
  logic [7:0]      flags;
  logic [CW_W-1:0] controlWord;

  modport master (
    output clk_en, load_start, load_data, load_valid, instruction, state, flags,
    input  load_ready, load_done, loaded, controlWord
  );

  modport slave (
    input  clk_en, load_start, load_data, load_valid, instruction, state, flags,
    output load_ready, load_done, loaded, controlWord
  );

endinterface

// File: rtl/ctl_store_ram.sv
// Single-port control-store RAM: synchronous write, registered read with enable.
module ctl_store_ram #(
  parameter int ADDR_W = 20,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic              clr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WORD_W-1:0] mem_r [DEPTH];

  // Write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  // Read register, forced to zero whenever the store is not serving lookups.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= {WORD_W{1'b0}};
    end else if (clr) begin
      rdata <= {WORD_W{1'b0}};
    end else if (re) begin
      rdata <= mem_r[addr];
    end
  end

endmodule

// File: rtl/control_store_loader.sv
// Writable control store: packs an MSB-first byte image into words, then
// serves {flags, instruction, state} lookups.
module control_store_loader
  import ctl_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int WORD_W = CW_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  control_store_loader_if.slave  bus
);

  localparam int                SHIFT_W  = WORD_W - 8;
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [1:0]        LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  ctl_state_t           state_r, state_nxt_s;
  logic [ADDR_W-1:0]    addr_r, addr_nxt_s;
  logic [1:0]           byte_cnt_r, byte_cnt_nxt_s;
  logic [SHIFT_W-1:0]   shift_r, shift_nxt_s;
  logic                 load_done_r, done_nxt_s;
  logic                 load_ready_r, loaded_r;
  logic                 we_s, re_s, clr_s;
  logic [LOOKUP_W-1:0]  lookup_s;
  logic [ADDR_W-1:0]    ram_addr_s;
  logic [WORD_W-1:0]    wdata_s, cw_s;

  assign lookup_s   = addr_of(bus.flags, bus.instruction, bus.state);
  assign ram_addr_s = (state_r == RUN) ? lookup_s[ADDR_W-1:0] : addr_r;
  assign wdata_s    = {shift_r, bus.load_data};

  // State, counters, packer and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      addr_r       <= {ADDR_W{1'b0}};
      byte_cnt_r   <= 2'd0;
      shift_r      <= {SHIFT_W{1'b0}};
      load_done_r  <= 1'b0;
      load_ready_r <= 1'b0;
      loaded_r     <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      addr_r       <= addr_nxt_s;
      byte_cnt_r   <= byte_cnt_nxt_s;
      shift_r      <= shift_nxt_s;
      load_done_r  <= done_nxt_s;
      load_ready_r <= (state_nxt_s == LOAD);
      loaded_r     <= (state_nxt_s == RUN);
    end
  end

  // Next-state, packing and RAM strobes; load_start beats any byte that cycle.
  always_comb begin
    state_nxt_s    = state_r;
    addr_nxt_s     = addr_r;
    byte_cnt_nxt_s = byte_cnt_r;
    shift_nxt_s    = shift_r;
    done_nxt_s     = 1'b0;
    we_s           = 1'b0;
    re_s           = 1'b0;
    clr_s          = (state_r != RUN) || bus.load_start;
    if (bus.load_start) begin
      state_nxt_s    = LOAD;
      addr_nxt_s     = {ADDR_W{1'b0}};
      byte_cnt_nxt_s = 2'd0;
      shift_nxt_s    = {SHIFT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: state_nxt_s = IDLE;
        LOAD: begin
          if (bus.load_valid) begin
            if (byte_cnt_r == LAST_BYTE) begin
              we_s           = 1'b1;
              addr_nxt_s     = addr_r + ADDR_ONE;
              byte_cnt_nxt_s = 2'd0;
              shift_nxt_s    = {SHIFT_W{1'b0}};
              if (addr_r == ADDR_MAX) begin
                state_nxt_s = RUN;
                done_nxt_s  = 1'b1;
              end else begin
                state_nxt_s = LOAD;
              end
            end else begin
              shift_nxt_s    = {shift_r[SHIFT_W-9:0], bus.load_data};
              byte_cnt_nxt_s = byte_cnt_r + 2'd1;
            end
          end else begin
            state_nxt_s = LOAD;
          end
        end
        RUN:     re_s        = bus.clk_en;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  ctl_store_ram #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we_s),
    .re    (re_s),
    .clr   (clr_s),
    .addr  (ram_addr_s),
    .wdata (wdata_s),
    .rdata (cw_s)
  );

  assign bus.load_ready  = load_ready_r;
  assign bus.load_done   = load_done_r;
  assign bus.loaded      = loaded_r;
  assign bus.controlWord = cw_s;

endmodule
